// File: rtl/ifid_stage_pkg.sv
// Shared pipeline definitions: MIPS opcode constants, link register index
// and the IF/ID skid FSM encoding.
package ifid_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [4:0] LINK_REG = 5'd31;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_HOLD   = 1'b1
    } ifid_state_e;

endpackage

// File: rtl/ifid_stage_field_decode.sv
// Register-field and control-flag decode of the instruction held in the
// IF/ID register; all outputs are forced to zero for an empty register.
module ifid_field_decode
    import ifid_stage_pkg::*;
(
    input  logic        valid,
    input  logic [31:0] instr,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic        jal,
    output logic        alusrc
);

    logic [5:0] opcode;
    logic       unused_low_bits;

    assign opcode          = instr[31:26];
    assign unused_low_bits = ^instr[10:0];

    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        rs     = '0;
        rt     = '0;
        rd     = '0;
        jal    = 1'b0;
        alusrc = 1'b0;
        if (valid) begin
            rs = instr[25:21];
            rt = instr[20:16];
            unique case (opcode)
                OP_RTYPE: rd = instr[15:11];
                OP_JAL: begin
                    rd  = LINK_REG;
                    jal = 1'b1;
                end
                default:  rd = instr[20:16];
            endcase
            alusrc = !(opcode inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_J, OP_JAL});
        end
    end

endmodule

// File: rtl/ifid_stage.sv
// IF/ID pipeline register with a one-entry skid buffer so fetch can keep
// issuing for one cycle after decode stalls; includes a stall-cycle counter.
module ifid_stage
    import ifid_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] if_pc,
    input  logic [DATA_W-1:0] if_instr,
    output logic              ifid_ready,
    input  logic              stall,
    input  logic              flush,
    output logic              ifid_valid,
    output logic [DATA_W-1:0] ifid_pc,
    output logic [DATA_W-1:0] ifid_pc4,
    output logic [DATA_W-1:0] ifid_instr,
    output logic [4:0]        ifid_rs,
    output logic [4:0]        ifid_rt,
    output logic [4:0]        ifid_rd,
    output logic              ifid_jal,
    output logic              ifid_alusrc,
    output logic [CNT_W-1:0]  stall_cnt
);

    ifid_state_e       state_q, state_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] skid_pc_q, skid_pc_d;
    logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;

    // State register. Skid occupancy is the FSM state itself.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_NORMAL;
        else     state_q <= state_d;
    end

    // Next-state logic; flush overrides stall and accept.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_NORMAL;
        end else begin
            unique case (state_q)
                ST_NORMAL: if (stall && accept) state_d = ST_HOLD;
                ST_HOLD:   if (!stall)          state_d = ST_NORMAL;
                default:                        state_d = ST_NORMAL;
            endcase
        end
    end

    // Output logic.
    always_comb begin
        ifid_ready = (state_q == ST_NORMAL);
    end

    assign accept = if_valid && ifid_ready;

    always_comb begin
        valid_d      = valid_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (state_q == ST_NORMAL) begin
            if (!stall) begin
                valid_d = accept;
                if (accept) begin
                    pc_d    = if_pc;
                    instr_d = if_instr;
                end
            end else if (accept) begin
                skid_pc_d    = if_pc;
                skid_instr_d = if_instr;
            end
        end else if (!stall) begin
            valid_d = 1'b1;
            pc_d    = skid_pc_q;
            instr_d = skid_instr_q;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && valid_q && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    // NOTE: the payload registers are reset as well so the visible PC/instr read 0 in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            instr_q      <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            cnt_q        <= '0;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            cnt_q        <= cnt_d;
        end
    end

    assign ifid_valid = valid_q;
    assign ifid_pc    = pc_q;
    assign ifid_pc4   = pc_q + DATA_W'(4);
    assign ifid_instr = instr_q;
    assign stall_cnt  = cnt_q;

    ifid_field_decode u_field_decode (
        .valid  (valid_q),
        .instr  (instr_q[31:0]),
        .rs     (ifid_rs),
        .rt     (ifid_rt),
        .rd     (ifid_rd),
        .jal    (ifid_jal),
        .alusrc (ifid_alusrc)
    );

endmodule

// File: tb/tb_ifid_stage.sv
// Self-checking bench for ifid_stage: directed scenarios plus a randomized
// fetch/stall stream checked against an in-order scoreboard.
module tb_ifid_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_valid;
    logic [DATA_W-1:0] if_pc;
    logic [DATA_W-1:0] if_instr;
    logic              ifid_ready;
    logic              stall;
    logic              flush;
    logic              ifid_valid;
    logic [DATA_W-1:0] ifid_pc;
    logic [DATA_W-1:0] ifid_pc4;
    logic [DATA_W-1:0] ifid_instr;
    logic [4:0]        ifid_rs;
    logic [4:0]        ifid_rt;
    logic [4:0]        ifid_rd;
    logic              ifid_jal;
    logic              ifid_alusrc;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;
    entry_t sb_q[$];

    always #5 clk = ~clk;

    ifid_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .ifid_ready  (ifid_ready),
        .stall       (stall),
        .flush       (flush),
        .ifid_valid  (ifid_valid),
        .ifid_pc     (ifid_pc),
        .ifid_pc4    (ifid_pc4),
        .ifid_instr  (ifid_instr),
        .ifid_rs     (ifid_rs),
        .ifid_rt     (ifid_rt),
        .ifid_rd     (ifid_rd),
        .ifid_jal    (ifid_jal),
        .ifid_alusrc (ifid_alusrc),
        .stall_cnt   (stall_cnt)
    );

    // Reference decode, written from the MIPS encoding.
    function automatic logic [4:0] ref_rd(input logic [31:0] ins);
        if (ins[31:26] == 6'd0)      return ins[15:11];
        else if (ins[31:26] == 6'd3) return 5'd31;
        else                         return ins[20:16];
    endfunction

    function automatic logic ref_alusrc(input logic [31:0] ins);
        case (ins[31:26])
            6'd0, 6'd2, 6'd3, 6'd4, 6'd5: return 1'b0;
            default:                      return 1'b1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic st, input logic fl);
        if_valid = v;
        if_pc    = pc;
        if_instr = ins;
        stall    = st;
        flush    = fl;
    endtask

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cmp_entry(input string name, input entry_t e);
        cmp({name, "_pc"},     ifid_pc,     e.pc);
        cmp({name, "_instr"},  ifid_instr,  e.instr);
        cmp({name, "_rs"},     {27'd0, ifid_rs}, {27'd0, e.instr[25:21]});
        cmp({name, "_rt"},     {27'd0, ifid_rt}, {27'd0, e.instr[20:16]});
        cmp({name, "_rd"},     {27'd0, ifid_rd}, {27'd0, ref_rd(e.instr)});
        cmp({name, "_alusrc"}, {31'd0, ifid_alusrc}, {31'd0, ref_alusrc(e.instr)});
        cmp({name, "_jal"},    {31'd0, ifid_jal}, {31'd0, e.instr[31:26] == 6'd3});
    endtask

    task automatic apply_reset();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        cmp("reset_valid", {31'd0, ifid_valid}, 32'd0);
        cmp("reset_ready", {31'd0, ifid_ready}, 32'd1);
        cmp("reset_pc",    ifid_pc,    32'd0);
        cmp("reset_instr", ifid_instr, 32'd0);
        cmp("reset_cnt",   {24'd0, stall_cnt}, 32'd0);
        cmp("reset_rd",    {27'd0, ifid_rd}, 32'd0);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        apply_reset();
        drive(1'b1, 32'h100, 32'h012A4020, 1'b0, 1'b0);
        tick();
        cmp("basic_valid", {31'd0, ifid_valid}, 32'd1);
        cmp("basic_pc4",   ifid_pc4, 32'h104);
        cmp_entry("basic", '{pc: 32'h100, instr: 32'h012A4020});
        cmp("basic_rs9",  {27'd0, ifid_rs}, 32'd9);
        cmp("basic_rt10", {27'd0, ifid_rt}, 32'd10);
        cmp("basic_rd8",  {27'd0, ifid_rd}, 32'd8);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        cmp("bubble_valid", {31'd0, ifid_valid}, 32'd0);
        cmp("bubble_fields", {17'd0, ifid_rs, ifid_rt, ifid_rd}, 32'd0);
        cmp("bubble_flags", {30'd0, ifid_jal, ifid_alusrc}, 32'd0);
    endtask

    task automatic test_decode();
        apply_reset();
        drive(1'b1, 32'h200, 32'h0C000040, 1'b0, 1'b0);
        tick();
        cmp("jal_flag",   {31'd0, ifid_jal}, 32'd1);
        cmp("jal_rd",     {27'd0, ifid_rd}, 32'd31);
        cmp("jal_alusrc", {31'd0, ifid_alusrc}, 32'd0);
        drive(1'b1, 32'h204, 32'h8D280004, 1'b0, 1'b0);
        tick();
        cmp("lw_alusrc", {31'd0, ifid_alusrc}, 32'd1);
        cmp("lw_rd",     {27'd0, ifid_rd}, 32'd8);
        cmp("lw_jal",    {31'd0, ifid_jal}, 32'd0);
        drive(1'b1, 32'hFFFFFFFC, 32'h1109FFFE, 1'b0, 1'b0);
        tick();
        cmp("wrap_pc4",   ifid_pc4, 32'h0);
        cmp_entry("beq", '{pc: 32'hFFFFFFFC, instr: 32'h1109FFFE});
    endtask

    task automatic test_stall_skid();
        apply_reset();
        drive(1'b1, 32'hA0, 32'h012A4020, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hB0, 32'h8D280004, 1'b1, 1'b0);
        tick();
        cmp("skid_ready0", {31'd0, ifid_ready}, 32'd0);
        cmp("skid_holdA",  ifid_pc, 32'hA0);
        drive(1'b1, 32'hC0, 32'h0C000040, 1'b1, 1'b0);
        tick();
        tick();
        cmp("skid_holdA2", ifid_pc, 32'hA0);
        cmp("skid_cnt",    {24'd0, stall_cnt}, 32'd3);
        stall = 1'b0;
        tick();
        cmp_entry("skid_B", '{pc: 32'hB0, instr: 32'h8D280004});
        cmp("skid_ready1", {31'd0, ifid_ready}, 32'd1);
        tick();
        cmp_entry("skid_C", '{pc: 32'hC0, instr: 32'h0C000040});
        cmp("skid_cnt_final", {24'd0, stall_cnt}, 32'd3);
        if_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush_hold();
        apply_reset();
        drive(1'b1, 32'h300, 32'h012A4020, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h304, 32'h8D280004, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h308, 32'h012A4020, 1'b1, 1'b1);
        tick();
        cmp("flush_valid", {31'd0, ifid_valid}, 32'd0);
        cmp("flush_ready", {31'd0, ifid_ready}, 32'd1);
        cmp("flush_fields", {17'd0, ifid_rs, ifid_rt, ifid_rd}, 32'd0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        cmp("flush_skid_empty", {31'd0, ifid_valid}, 32'd0);
    endtask

    task automatic test_saturate();
        apply_reset();
        drive(1'b1, 32'h400, 32'h012A4020, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) tick();
        cmp("sat_cnt", {24'd0, stall_cnt}, 32'd255);
        stall = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive(1'b1, 32'h500, 32'h012A4020, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h504, 32'h8D280004, 1'b1, 1'b0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        cmp("arst_valid", {31'd0, ifid_valid}, 32'd0);
        cmp("arst_ready", {31'd0, ifid_ready}, 32'd1);
        cmp("arst_pc",    ifid_pc, 32'd0);
        cmp("arst_cnt",   {24'd0, stall_cnt}, 32'd0);
        tick();
        rst = 1'b0;
        drive(1'b1, 32'h600, 32'h8D280004, 1'b0, 1'b0);
        tick();
        cmp_entry("arst_first", '{pc: 32'h600, instr: 32'h8D280004});
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        cmp("arst_no_dup", {31'd0, ifid_valid}, 32'd0);
    endtask

    task automatic test_back_to_back();
        logic   hold_m;
        logic   acc;
        entry_t e;
        int     drain;
        logic [31:0] ops [4];
        ops[0] = 32'h00000020; ops[1] = 32'h8C000000;
        ops[2] = 32'h0C000000; ops[3] = 32'h10000000;
        apply_reset();
        sb_q.delete();
        hold_m = 1'b0;
        for (int i = 0; i < 200; i++) begin
            drive($urandom_range(0, 3) != 0, 32'h1000 + 32'(i * 4),
                  ops[$urandom_range(0, 3)] | ($urandom & 32'h03FFFFFF),
                  $urandom_range(0, 9) < 3, 1'b0);
            cmp("b2b_ready", {31'd0, ifid_ready}, {31'd0, !hold_m});
            if (ifid_valid && !stall) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b2b_extra got pc %h expected none", ifid_pc);
                end else begin
                    e = sb_q.pop_front();
                    cmp_entry("b2b", e);
                end
            end
            acc = if_valid && !hold_m;
            if (acc) sb_q.push_back('{pc: if_pc, instr: if_instr});
            if (hold_m && !stall)      hold_m = 1'b0;
            else if (stall && acc)     hold_m = 1'b1;
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        drain = 0;
        while (sb_q.size() != 0 && drain < 20) begin
            if (ifid_valid) begin
                e = sb_q.pop_front();
                cmp_entry("drain", e);
            end
            tick();
            drain++;
        end
        cmp("b2b_lost", sb_q.size(), 32'd0);
        cmp("b2b_idle", {31'd0, ifid_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        test_reset();
        test_basic();
        test_decode();
        test_stall_skid();
        test_flush_hold();
        test_saturate();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifid_stage.md
IFID_STAGE -- requirements
Module: ifid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of PC and instruction.
REQ-002 SHALL have parameter CNT_W, default 8, width of the stall-cycle counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 if_valid  input  1  fetch stage presents an instruction this cycle.
REQ-006 if_pc  input  DATA_W  PC of the presented instruction.
REQ-007 if_instr  input  DATA_W  instruction word from instruction memory.
REQ-008 ifid_ready  output  1  stage can accept; equals NOT skid_full.
REQ-009 stall  input  1  hazard request to hold the decode register.
REQ-010 flush  input  1  branch/jump redirect; kill decode register and skid entry.
REQ-011 ifid_valid  output  1  decode register holds a live instruction.
REQ-012 ifid_pc, ifid_pc4, ifid_instr  output  DATA_W  registered PC, PC+4, instruction.
REQ-013 ifid_rs, ifid_rt, ifid_rd  output  5  register fields feeding forwarding and hazard logic.
REQ-014 ifid_jal, ifid_alusrc  output  1  decoded JAL and ALU-immediate flags.
REQ-015 stall_cnt  output  CNT_W  saturating count of cycles with stall=1 and ifid_valid=1.

Function
REQ-016 Accept: transfer occurs when if_valid AND ifid_ready; latency fetch-to-ifid_valid is 1 cycle when not stalled.
REQ-017 FSM states: NORMAL (skid empty) and HOLD (skid full); reset state NORMAL.
REQ-018 NORMAL, stall=0: decode register loads the accepted instruction, else ifid_valid<=0.
REQ-019 NORMAL, stall=1, accept: decode register held; accepted instruction written to skid; go HOLD.
REQ-020 NORMAL, stall=1, no accept: decode register held; stay NORMAL.
REQ-021 HOLD: ifid_ready=0; no accept; stall=1 holds both entries; stall=0 moves skid to decode register, goes NORMAL.
REQ-022 flush has priority over stall and accept: ifid_valid<=0, skid cleared, same-cycle fetch dropped, state NORMAL.
REQ-023 Ordering: no instruction is lost or duplicated; skid contents always leave before any newer fetch.
REQ-024 ifid_pc4 = ifid_pc + 4, modulo 2^DATA_W (wrap 0xFFFFFFFC -> 0x00000000).
REQ-025 ifid_rs = instr[25:21]; ifid_rt = instr[20:16].
REQ-026 ifid_rd = instr[15:11] for opcode 000000; 5'd31 for JAL (opcode 000011); else instr[20:16].
REQ-027 ifid_jal = 1 only for opcode 000011.
REQ-028 ifid_alusrc = 1 for opcode not in {000000, 000100, 000101, 000010, 000011}.
REQ-029 When ifid_valid=0, ifid_rs/rt/rd SHALL be 0 and ifid_jal/alusrc 0, so no forwarding match fires.
REQ-030 Decode outputs are combinational from the registered instruction; no extra latency.
REQ-031 stall_cnt increments by 1 per qualifying cycle, holds at all-ones, never wraps.

Reset
REQ-032 On rst=1, immediately: ifid_valid=0, skid empty, state NORMAL, ifid_pc/pc4/instr=0, stall_cnt=0, ifid_ready=1.
REQ-033 Reset mid-HOLD SHALL discard both entries; first accept after release behaves per REQ-018.

Structure
REQ-034 Opcode constants (RTYPE, BEQ, BNE, J, JAL), the link-register index 31 and FSM state encoding SHALL live in a shared pipeline package.
REQ-035 Decode of rs/rt/rd/jal/alusrc SHALL be one sub-module, ifid_field_decode, instantiated once on the decode register.

Verification
REQ-036 Reset release, if_valid=1, instr 0x012A4020 (add $8,$9,$10), pc 0x100 -> next cycle ifid_valid=1, rs=9, rt=10, rd=8, pc4=0x104, alusrc=0.
REQ-037 stall=1 for 3 cycles with continuous fetch A,B,C -> A held, B in skid, ifid_ready=0 after 1 cycle, C not accepted; stall=0 -> B then C in order; stall_cnt=3.
REQ-038 HOLD state, flush=1 with stall=1 -> next cycle ifid_valid=0, ifid_ready=1, rs/rt/rd=0, skid empty.
REQ-039 instr 0x0C000040 (jal) -> ifid_jal=1, rd=31, alusrc=0; instr 0x8D280004 (lw) -> alusrc=1, rd=8.
REQ-040 pc 0xFFFFFFFC -> ifid_pc4=0x00000000; 300 qualifying stall cycles -> stall_cnt=255.
REQ-041 rst asserted asynchronously mid-HOLD -> outputs reach reset values before next clock edge.
